instr_encoder_loader: RTL and testbench



---
 rtl/instr_encoder_loader_pkg.sv | 47 ++++
 rtl/instr_encoder_loader_word_encoder.sv | 56 +++++
 rtl/instr_encoder_loader.sv | 135 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the instruction encoder/loader and the CPU decoder:
// internal opcode enum, MIPS op/func values, field positions and word builders.
package instr_encoder_loader_pkg;

  typedef enum logic [4:0] {
    OPC_ADD   = 5'd0,  OPC_ADDU  = 5'd1,  OPC_SUB   = 5'd2,  OPC_SUBU  = 5'd3,
    OPC_AND   = 5'd4,  OPC_OR    = 5'd5,  OPC_XOR   = 5'd6,  OPC_NOR   = 5'd7,
    OPC_SLT   = 5'd8,  OPC_SLTU  = 5'd9,  OPC_SLL   = 5'd10, OPC_SRL   = 5'd11,
    OPC_SRA   = 5'd12, OPC_SLLV  = 5'd13, OPC_SRLV  = 5'd14, OPC_SRAV  = 5'd15,
    OPC_JR    = 5'd16, OPC_ADDI  = 5'd17, OPC_ADDIU = 5'd18, OPC_SLTI  = 5'd19,
    OPC_SLTIU = 5'd20, OPC_ANDI  = 5'd21, OPC_ORI   = 5'd22, OPC_XORI  = 5'd23,
    OPC_LUI   = 5'd24, OPC_BEQ   = 5'd25, OPC_BNE   = 5'd26, OPC_LW    = 5'd27,
    OPC_SW    = 5'd28, OPC_J     = 5'd29, OPC_JAL   = 5'd30, OPC_ILLEGAL = 5'd31
  } opc_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08, FN_ADD  = 6'h20, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  localparam int OP_LSB = 26, RS_LSB = 21, RT_LSB = 16, RD_LSB = 11, SH_LSB = 6;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return (32'(OP_RTYPE) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
           (32'(rd) << RD_LSB) | (32'(sh) << SH_LSB) | 32'(fn);
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] tgt);
    return (32'(op) << OP_LSB) | 32'(tgt);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_word_encoder.sv
// Combinational opcode+fields to 32-bit MIPS word; also usable as a golden model.
module instr_word_encoder
  import instr_encoder_loader_pkg::*;
(
  input  opc_e        opc_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (opc_i)
      OPC_ADD:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
      OPC_ADDU:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_ADDU);
      OPC_SUB:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
      OPC_SUBU:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SUBU);
      OPC_AND:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_AND);
      OPC_OR:    word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_OR);
      OPC_XOR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_XOR);
      OPC_NOR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_NOR);
      OPC_SLT:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SLT);
      OPC_SLTU:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SLTU);
      // immediate shifts take their amount from shamt, so rs is meaningless
      OPC_SLL:   word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SLL);
      OPC_SRL:   word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SRL);
      OPC_SRA:   word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SRA);
      OPC_SLLV:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SLLV);
      OPC_SRLV:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SRLV);
      OPC_SRAV:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SRAV);
      OPC_JR:    word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
      OPC_ADDI:  word_o = i_word(OP_ADDI,  rs_i, rt_i, imm_i);
      OPC_ADDIU: word_o = i_word(OP_ADDIU, rs_i, rt_i, imm_i);
      OPC_SLTI:  word_o = i_word(OP_SLTI,  rs_i, rt_i, imm_i);
      OPC_SLTIU: word_o = i_word(OP_SLTIU, rs_i, rt_i, imm_i);
      OPC_ANDI:  word_o = i_word(OP_ANDI,  rs_i, rt_i, imm_i);
      OPC_ORI:   word_o = i_word(OP_ORI,   rs_i, rt_i, imm_i);
      OPC_XORI:  word_o = i_word(OP_XORI,  rs_i, rt_i, imm_i);
      OPC_LUI:   word_o = i_word(OP_LUI,   5'd0, rt_i, imm_i);
      OPC_BEQ:   word_o = i_word(OP_BEQ,   rs_i, rt_i, imm_i);
      OPC_BNE:   word_o = i_word(OP_BNE,   rs_i, rt_i, imm_i);
      OPC_LW:    word_o = i_word(OP_LW,    rs_i, rt_i, imm_i);
      OPC_SW:    word_o = i_word(OP_SW,    rs_i, rt_i, imm_i);
      OPC_J:     word_o = j_word(OP_J,   target_i);
      OPC_JAL:   word_o = j_word(OP_JAL, target_i);
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes loader requests into MIPS words and writes them to imem at an auto-incrementing address.
// ENC_READBACK_EN adds a CHECK state that compares imem_rdata against the written word (rb_err).
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RST_BASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opc,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       imem_rdata,
`ifdef ENC_READBACK_EN
  output logic              rb_err,
`endif
  output logic [15:0]       wr_count,
  output logic              err
);

`ifdef ENC_READBACK_EN
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CHECK} state_e;
  logic rb_err_q, rb_err_d;
`else
  typedef enum logic {S_IDLE, S_WRITE} state_e;
  logic unused_rdata;
  assign unused_rdata = ^imem_rdata;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       enc_word;
  logic              enc_illegal;

  instr_word_encoder u_enc (
    .opc_i    (opc_e'(in_opc)),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .shamt_i  (in_shamt),
    .imm_i    (in_imm),
    .target_i (in_target),
    .word_o   (enc_word),
    .illegal_o(enc_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= RST_BASE;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef ENC_READBACK_EN
      rb_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef ENC_READBACK_EN
      rb_err_q <= rb_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef ENC_READBACK_EN
    rb_err_d = rb_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // a base load in the accept cycle redirects this very word
        if (base_load) addr_d = base_addr;
        if (in_valid) begin
          if (enc_illegal) begin
            err_d = 1'b1;
          end else begin
            wdata_d = enc_word;
            state_d = S_WRITE;
          end
        end
      end
`ifdef ENC_READBACK_EN
      S_WRITE: state_d = S_CHECK;
      S_CHECK: begin
        if (imem_rdata != wdata_q) rb_err_d = 1'b1;
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        state_d = S_IDLE;
      end
`else
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready   = (state_q == S_IDLE);
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign wr_count   = cnt_q;
  assign err        = err_q;
`ifdef ENC_READBACK_EN
  assign rb_err     = rb_err_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: expected writes are queued at issue time,
// a negedge monitor pops and compares on every imem_we.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opc, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        base_load;
  logic [7:0]  base_addr;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;
  logic [15:0] wr_count;
  logic        err;

  int checks   = 0;
  int failures = 0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .RST_BASE(8'h00)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opc(in_opc), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .base_load(base_load), .base_addr(base_addr),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .wr_count(wr_count), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
    in_opc = opc; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
  task automatic send(input logic [4:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic bl, input logic [7:0] ba,
                      input logic bl_in_write, input logic legal,
                      input logic [7:0] eaddr, input logic [31:0] edata);
    if (legal) exp_q.push_back({eaddr, edata});
    drive(opc, rs, rt, rd, sh, imm, tgt);
    base_load = bl; base_addr = ba; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    base_load = bl_in_write; base_addr = 8'h40;
    wait_idle();
    base_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; base_load = 1'b0; base_addr = 8'h00;
    imem_rdata = 32'h0;
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);

    fork
      forever begin
        @(negedge clk);
        if (imem_we === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", {24'd0, imem_addr}, 32'hFFFF_FFFF);
          end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            check("wr_addr", {24'd0, imem_addr}, {24'd0, e[39:32]});
            check("wr_data", imem_wdata, e[31:0]);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_we",    {31'd0, imem_we},  32'd0);
    check("rst_addr",  {24'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_count", {16'd0, wr_count}, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);

    // add with shamt masked
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 32'h0022_1820);
    check("add_addr",  {24'd0, imem_addr}, 32'd1);
    check("add_count", {16'd0, wr_count}, 32'd1);

    // addi, then j at the next address
    send(5'd17, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 32'h2008_FFFF);
    send(5'd29, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 32'h0810_0000);

    // sll forces rs to 0
    send(5'd10, 5'd5, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 32'h0001_1100);
    check("sll_addr",  {24'd0, imem_addr}, 32'd4);
    check("sll_count", {16'd0, wr_count}, 32'd4);

    // illegal opcode: no write, sticky err, addr/count frozen
    send(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    check("ill_err",   {31'd0, err}, 32'd1);
    check("ill_addr",  {24'd0, imem_addr}, 32'd4);
    check("ill_count", {16'd0, wr_count}, 32'd4);
    send(5'd5, 5'd4, 5'd5, 5'd6, 5'd9, 16'h0, 26'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 32'h0085_3025);
    check("or_count", {16'd0, wr_count}, 32'd5);
    check("err_sticky", {31'd0, err}, 32'd1);

    // base load alone, then wrap; base load during WRITE is ignored
    base_load = 1'b1; base_addr = 8'hFF;
    @(posedge clk); #1;
    base_load = 1'b0;
    check("base_addr", {24'd0, imem_addr}, 32'hFF);
    send(5'd24, 5'd3, 5'd7, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 32'h3C07_1234);
    send(5'd28, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 32'hAFBF_0010);
    check("wrap_addr", {24'd0, imem_addr}, 32'h01);

    // base load coinciding with accept redirects the word; jr clears rt/rd/shamt
    send(5'd16, 5'd31, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 8'h80, 1'b0, 1'b1, 8'h80, 32'h03E0_0008);
    check("bl_acc_addr", {24'd0, imem_addr}, 32'h81);

    // continuous valid: ready alternates, two back-to-back writes
    exp_q.push_back({8'h81, 32'h0022_1820});
    exp_q.push_back({8'h82, 32'h0022_1820});
    drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    check("tog_0", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("tog_1", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("tog_2", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("tog_3", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_idle();
    check("tog_count", {16'd0, wr_count}, 32'd10);
    check("tog_addr",  {24'd0, imem_addr}, 32'h83);

    // reset during WRITE
    exp_q.push_back({8'h83, 32'h0022_1826});
    drive(5'd6, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    check("mid_we", {31'd0, imem_we}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_we",    {31'd0, imem_we},  32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd1);
    check("mrst_addr",  {24'd0, imem_addr}, 32'd0);
    check("mrst_wdata", imem_wdata, 32'd0);
    check("mrst_count", {16'd0, wr_count}, 32'd0);
    check("mrst_err",   {31'd0, err}, 32'd0);

    repeat (3) @(posedge clk); #1;
    check("sb_drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
